// File: rtl/toom8_pkg.sv
// Shared constants and types for the Toom-Cook-8 evaluation front end.
package toom8_pkg;

    localparam int LIMB_W = 128;
    localparam int NLIMB  = 8;
    localparam int OP_W   = LIMB_W * NLIMB;
    localparam int PROD_W = 2 * OP_W;

    // Output widths per evaluation point
    localparam int W_P0   = 129;   // p(0)
    localparam int W_P1   = 132;   // p(+1), p(-1)
    localparam int W_P2   = 139;   // p(+2), p(-2)
    localparam int W_P4   = 144;   // p(+4), p(-4)
    localparam int W_P3   = 148;   // p(+3), p(-3)
    localparam int W_PH   = 149;   // 2^7 p(+-1/2)
    localparam int W_PQ   = 150;   // 4^7 p(+-1/4)
    localparam int W_P8   = 155;   // p(8)
    localparam int W_PINF = 129;   // p(inf)

    // Internal accumulator is wider than every output, so no sum can wrap
    localparam int ACC_W  = 160;

    typedef logic [NLIMB-1:0][LIMB_W-1:0] limbs_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

    // Zero-extend a limb into a non-negative signed accumulator value
    function automatic acc_t limb_ext(input logic [LIMB_W-1:0] l);
        return acc_t'({{(ACC_W - LIMB_W){1'b0}}, l});
    endfunction

endpackage

// File: rtl/toom8_poly_eval.sv
// Combinational evaluation of one 8-limb operand at the 15 Toom-8 points.
// All weights are formed with shifts and adds only.
module toom8_poly_eval
    import toom8_pkg::*;
(
    input  limbs_t                   limbs,
    output logic signed [W_P0-1:0]   p0,
    output logic signed [W_P1-1:0]   pp1,
    output logic signed [W_P1-1:0]   pm1,
    output logic signed [W_P2-1:0]   pp2,
    output logic signed [W_P2-1:0]   pm2,
    output logic signed [W_P4-1:0]   pp4,
    output logic signed [W_P4-1:0]   pm4,
    output logic signed [W_P3-1:0]   pp3,
    output logic signed [W_P3-1:0]   pm3,
    output logic signed [W_PH-1:0]   pph,
    output logic signed [W_PH-1:0]   pmh,
    output logic signed [W_PQ-1:0]   ppq,
    output logic signed [W_PQ-1:0]   pmq,
    output logic signed [W_P8-1:0]   pp8,
    output logic signed [W_PINF-1:0] pinf
);

    // Multiply by a small constant using shift/add
    function automatic acc_t scale(input acc_t v, input int k);
        case (k)
            2:       return v <<< 1;
            3:       return (v <<< 1) + v;
            4:       return v <<< 2;
            8:       return v <<< 3;
            default: return v;
        endcase
    endfunction

    // Horner evaluation at integer point +k or -k (top limb first)
    function automatic acc_t eval_int(input limbs_t l, input int k, input logic neg);
        acc_t acc;
        acc = '0;
        for (int i = NLIMB - 1; i >= 0; i--) begin
            if (neg) acc = limb_ext(l[i]) - scale(acc, k);
            else     acc = scale(acc, k) + limb_ext(l[i]);
        end
        return acc;
    endfunction

    // k^7 * p(+-1/k): reversed Horner so limb0 ends up with weight k^7
    function automatic acc_t eval_frac(input limbs_t l, input int k, input logic neg);
        acc_t acc;
        acc = '0;
        for (int i = 0; i < NLIMB; i++) begin
            if (neg && i[0]) acc = scale(acc, k) - limb_ext(l[i]);
            else             acc = scale(acc, k) + limb_ext(l[i]);
        end
        return acc;
    endfunction

    assign p0   = W_P0'(limb_ext(limbs[0]));
    assign pinf = W_PINF'(limb_ext(limbs[NLIMB-1]));
    assign pp1  = W_P1'(eval_int(limbs, 1, 1'b0));
    assign pm1  = W_P1'(eval_int(limbs, 1, 1'b1));
    assign pp2  = W_P2'(eval_int(limbs, 2, 1'b0));
    assign pm2  = W_P2'(eval_int(limbs, 2, 1'b1));
    assign pp4  = W_P4'(eval_int(limbs, 4, 1'b0));
    assign pm4  = W_P4'(eval_int(limbs, 4, 1'b1));
    assign pp3  = W_P3'(eval_int(limbs, 3, 1'b0));
    assign pm3  = W_P3'(eval_int(limbs, 3, 1'b1));
    assign pph  = W_PH'(eval_frac(limbs, 2, 1'b0));
    assign pmh  = W_PH'(eval_frac(limbs, 2, 1'b1));
    assign ppq  = W_PQ'(eval_frac(limbs, 4, 1'b0));
    assign pmq  = W_PQ'(eval_frac(limbs, 4, 1'b1));
    assign pp8  = W_P8'(eval_int(limbs, 8, 1'b0));

endmodule

// File: rtl/toom8_eval.sv
// Toom-Cook-8 evaluation front end: two register stages around a pair of
// polynomial evaluators. Optional golden product enabled by macro
// TOOM8_REF_PRODUCT_EN; without it, product is constant zero.
module toom8_eval
    import toom8_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OP_W-1:0]          X,
    input  logic [OP_W-1:0]          Y,
    output logic [PROD_W-1:0]        product,
    output logic signed [W_P0-1:0]   a0,  b0,
    output logic signed [W_P1-1:0]   a1,  a2,  b1,  b2,
    output logic signed [W_P2-1:0]   a3,  a4,  b3,  b4,
    output logic signed [W_P4-1:0]   a5,  a6,  b5,  b6,
    output logic signed [W_P3-1:0]   a7,  a8,  b7,  b8,
    output logic signed [W_PH-1:0]   a9,  a10, b9,  b10,
    output logic signed [W_PQ-1:0]   a11, a12, b11, b12,
    output logic signed [W_P8-1:0]   a13, b13,
    output logic signed [W_PINF-1:0] ainf, binf
);

    logic [OP_W-1:0] x_p0, y_p0;

    logic signed [W_P0-1:0]   ex0,  ey0;
    logic signed [W_P1-1:0]   ex1,  ex2,  ey1,  ey2;
    logic signed [W_P2-1:0]   ex3,  ex4,  ey3,  ey4;
    logic signed [W_P4-1:0]   ex5,  ex6,  ey5,  ey6;
    logic signed [W_P3-1:0]   ex7,  ex8,  ey7,  ey8;
    logic signed [W_PH-1:0]   ex9,  ex10, ey9,  ey10;
    logic signed [W_PQ-1:0]   ex11, ex12, ey11, ey12;
    logic signed [W_P8-1:0]   ex13, ey13;
    logic signed [W_PINF-1:0] exinf, eyinf;

    // Stage 1: capture operands every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else begin
            x_p0 <= X;
            y_p0 <= Y;
        end
    end

    toom8_poly_eval u_eval_x (
        .limbs(limbs_t'(x_p0)),
        .p0(ex0),   .pp1(ex1),  .pm1(ex2),  .pp2(ex3),  .pm2(ex4),
        .pp4(ex5),  .pm4(ex6),  .pp3(ex7),  .pm3(ex8),  .pph(ex9),
        .pmh(ex10), .ppq(ex11), .pmq(ex12), .pp8(ex13), .pinf(exinf)
    );

    toom8_poly_eval u_eval_y (
        .limbs(limbs_t'(y_p0)),
        .p0(ey0),   .pp1(ey1),  .pm1(ey2),  .pp2(ey3),  .pm2(ey4),
        .pp4(ey5),  .pm4(ey6),  .pp3(ey7),  .pm3(ey8),  .pph(ey9),
        .pmh(ey10), .ppq(ey11), .pmq(ey12), .pp8(ey13), .pinf(eyinf)
    );

    // Stage 2: register X-side evaluations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0 <= '0;  a1 <= '0;  a2 <= '0;  a3 <= '0;  a4 <= '0;
            a5 <= '0;  a6 <= '0;  a7 <= '0;  a8 <= '0;  a9 <= '0;
            a10 <= '0; a11 <= '0; a12 <= '0; a13 <= '0; ainf <= '0;
        end else begin
            a0 <= ex0;   a1 <= ex1;   a2 <= ex2;   a3 <= ex3;   a4 <= ex4;
            a5 <= ex5;   a6 <= ex6;   a7 <= ex7;   a8 <= ex8;   a9 <= ex9;
            a10 <= ex10; a11 <= ex11; a12 <= ex12; a13 <= ex13; ainf <= exinf;
        end
    end

    // Stage 2: register Y-side evaluations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0 <= '0;  b1 <= '0;  b2 <= '0;  b3 <= '0;  b4 <= '0;
            b5 <= '0;  b6 <= '0;  b7 <= '0;  b8 <= '0;  b9 <= '0;
            b10 <= '0; b11 <= '0; b12 <= '0; b13 <= '0; binf <= '0;
        end else begin
            b0 <= ey0;   b1 <= ey1;   b2 <= ey2;   b3 <= ey3;   b4 <= ey4;
            b5 <= ey5;   b6 <= ey6;   b7 <= ey7;   b8 <= ey8;   b9 <= ey9;
            b10 <= ey10; b11 <= ey11; b12 <= ey12; b13 <= ey13; binf <= eyinf;
        end
    end

`ifdef TOOM8_REF_PRODUCT_EN
    // Stage 2: full-width reference product, aligned with the evaluations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) product <= '0;
        else     product <= PROD_W'(x_p0) * PROD_W'(y_p0);
    end
`else
    assign product = '0;
`endif

endmodule

// File: tb/tb_toom8_eval.sv
// Self-checking bench for toom8_eval: directed cases plus a random stream
// compared against a direct-summation polynomial model.
module tb_toom8_eval;

    logic clk, rst;
    logic [1023:0] X, Y;
    logic [2047:0] product;
    logic signed [128:0] a0, b0, ainf, binf;
    logic signed [131:0] a1, a2, b1, b2;
    logic signed [138:0] a3, a4, b3, b4;
    logic signed [143:0] a5, a6, b5, b6;
    logic signed [147:0] a7, a8, b7, b8;
    logic signed [148:0] a9, a10, b9, b10;
    logic signed [149:0] a11, a12, b11, b12;
    logic signed [154:0] a13, b13;

    int n_cmp = 0;
    int n_bad = 0;

    toom8_eval dut (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .product(product),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6),
        .a7(a7), .a8(a8), .a9(a9), .a10(a10), .a11(a11), .a12(a12),
        .a13(a13), .ainf(ainf),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
        .b7(b7), .b8(b8), .b9(b9), .b10(b10), .b11(b11), .b12(b12),
        .b13(b13), .binf(binf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // p(t) = sum limb_i * t^i, evaluated directly
    function automatic logic signed [159:0] ev_pt(input logic [1023:0] v, input int t);
        logic signed [159:0] s, pw, lv;
        s = 0; pw = 1;
        for (int i = 0; i < 8; i++) begin
            lv = $signed({32'd0, v[i*128 +: 128]});
            s = s + lv * pw;
            pw = pw * t;
        end
        return s;
    endfunction

    // k^7 * p(+-1/k) = sum (+-1)^i limb_i * k^(7-i)
    function automatic logic signed [159:0] ev_frac(input logic [1023:0] v, input int k, input bit neg);
        logic signed [159:0] s, w, lv;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            lv = $signed({32'd0, v[i*128 +: 128]});
            w = 1;
            for (int j = 0; j < 7 - i; j++) w = w * k;
            if (neg && (i % 2 == 1)) s = s - lv * w;
            else                     s = s + lv * w;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [159:0] obs, input logic signed [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1023:0] x, input logic [1023:0] y);
        logic [2047:0] pexp;
        chk({tag, ".a0"},   a0,   ev_pt(x, 0));
        chk({tag, ".a1"},   a1,   ev_pt(x, 1));
        chk({tag, ".a2"},   a2,   ev_pt(x, -1));
        chk({tag, ".a3"},   a3,   ev_pt(x, 2));
        chk({tag, ".a4"},   a4,   ev_pt(x, -2));
        chk({tag, ".a5"},   a5,   ev_pt(x, 4));
        chk({tag, ".a6"},   a6,   ev_pt(x, -4));
        chk({tag, ".a7"},   a7,   ev_pt(x, 3));
        chk({tag, ".a8"},   a8,   ev_pt(x, -3));
        chk({tag, ".a9"},   a9,   ev_frac(x, 2, 1'b0));
        chk({tag, ".a10"},  a10,  ev_frac(x, 2, 1'b1));
        chk({tag, ".a11"},  a11,  ev_frac(x, 4, 1'b0));
        chk({tag, ".a12"},  a12,  ev_frac(x, 4, 1'b1));
        chk({tag, ".a13"},  a13,  ev_pt(x, 8));
        chk({tag, ".ainf"}, ainf, $signed({32'd0, x[1023:896]}));
        chk({tag, ".b0"},   b0,   ev_pt(y, 0));
        chk({tag, ".b1"},   b1,   ev_pt(y, 1));
        chk({tag, ".b2"},   b2,   ev_pt(y, -1));
        chk({tag, ".b3"},   b3,   ev_pt(y, 2));
        chk({tag, ".b4"},   b4,   ev_pt(y, -2));
        chk({tag, ".b5"},   b5,   ev_pt(y, 4));
        chk({tag, ".b6"},   b6,   ev_pt(y, -4));
        chk({tag, ".b7"},   b7,   ev_pt(y, 3));
        chk({tag, ".b8"},   b8,   ev_pt(y, -3));
        chk({tag, ".b9"},   b9,   ev_frac(y, 2, 1'b0));
        chk({tag, ".b10"},  b10,  ev_frac(y, 2, 1'b1));
        chk({tag, ".b11"},  b11,  ev_frac(y, 4, 1'b0));
        chk({tag, ".b12"},  b12,  ev_frac(y, 4, 1'b1));
        chk({tag, ".b13"},  b13,  ev_pt(y, 8));
        chk({tag, ".binf"}, binf, $signed({32'd0, y[1023:896]}));
`ifdef TOOM8_REF_PRODUCT_EN
        pexp = 2048'(x) * 2048'(y);
`else
        pexp = '0;
`endif
        n_cmp++;
        assert (product === pexp) else begin
            n_bad++;
            $error("FAIL %s.product low128 observed=%h expected=%h", tag, product[127:0], pexp[127:0]);
        end
    endtask

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [1023:0] hx [0:39];
    logic [1023:0] hy [0:39];
    logic [1023:0] lx, ones, qx, qy;
    logic signed [159:0] m, e13;
    logic [2047:0] pones;

    initial begin
        ones = '1;
        rst = 1'b0;
        X = ones;
        Y = ones;

        // Reset must clear outputs without a clock edge
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all("rst_async", '0, '0);
        @(negedge clk);
        check_all("rst_hold", '0, '0);

        // Directed limb pattern; outputs remain 0 until two edges capture data
        lx = {128'd8, 128'd7, 128'd6, 128'd5, 128'd4, 128'd3, 128'd2, 128'd253};
        X = lx;
        Y = lx;
        rst = 1'b0;
        @(negedge clk);
        check_all("fill", '0, '0);
        @(negedge clk);
        chk("limb.a0", a0, 160'sd253);
        chk("limb.b0", b0, 160'sd253);
        chk("limb.ainf", ainf, 160'sd8);
        chk("limb.binf", binf, 160'sd8);
        chk("limb.a1", a1, 160'sd288);
        chk("limb.a2", a2, 160'sd248);
        chk("limb.a3", a3, 160'sd2045);
        chk("limb.a4", a4, -160'sd459);
        check_all("limb", lx, lx);

        // Worst case: every limb all ones
        X = ones;
        Y = ones;
        repeat (2) @(negedge clk);
        m = $signed({32'd0, {128{1'b1}}});
        e13 = m * 160'sd2396745;
        chk("worst.a13", a13, e13);
        chk("worst.b13", b13, e13);
        check_all("worst", ones, ones);
`ifdef TOOM8_REF_PRODUCT_EN
        pones = 2048'd1 - (2048'd1 << 1025);
`else
        pones = '0;
`endif
        n_cmp++;
        assert (product === pones) else begin
            n_bad++;
            $error("FAIL worst.product low128 observed=%h expected=%h", product[127:0], pones[127:0]);
        end

        // Random back-to-back stream, no bubbles
        for (int k = 0; k < 40; k++) begin
            if (k >= 2) check_all("stream", hx[k-2], hy[k-2]);
            hx[k] = rnd1024();
            hy[k] = rnd1024();
            X = hx[k];
            Y = hy[k];
            @(negedge clk);
        end
        check_all("stream", hx[38], hy[38]);
        @(negedge clk);
        check_all("stream", hx[39], hy[39]);

        // Mid-stream reset: in-flight pair is dropped, held input reappears
        X = rnd1024();
        Y = rnd1024();
        @(negedge clk);
        qx = rnd1024();
        qy = rnd1024();
        X = qx;
        Y = qy;
        #1 rst = 1'b1;
        #1 check_all("mid_rst", '0, '0);
        #2 rst = 1'b0;
        @(negedge clk);
        check_all("mid_fill", '0, '0);
        @(negedge clk);
        check_all("mid_resume", qx, qy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
